lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the byte-masked data memory (word-addressed, combinational read, byte-masked synchronous write) on behalf of the core.
- Accepts one byte-addressed RV32 load/store request at a time via a valid/ready handshake.
- Generates the memory word address, byte mask and lane-shifted write data; extracts and sign/zero-extends load data.
- Returns one response per request. Sits between the execute stage and the data memory.

Parameters:
- MEM_AW, 11, memory word-address width (o_mem_addr width).
- DEPTH_BYTES, 2048, bytes of backing memory; accesses with any byte at or above this are range errors.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  high only in IDLE
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, LSB-aligned
- o_rsp_valid  out  1  one-cycle response strobe; no backpressure
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  qualifies o_rsp_valid: bad funct3, range error, or misaligned access (feature off)
- o_mem_addr  out  MEM_AW  memory word address
- o_mem_wdata  out  32  lane-shifted write data
- o_mem_bmask  out  4  byte enables
- o_mem_wren  out  1  write enable
- i_mem_rdata  in  32  combinational read data for o_mem_addr

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: state IDLE; o_req_ready=1; o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0; o_mem_wren=0, o_mem_bmask=0, o_mem_addr=0, o_mem_wdata=0.
- Handshake: the request is registered on the edge where i_req_valid && o_req_ready. No further request is accepted until the state returns to IDLE.
- States:
  - IDLE → ACC0 on a valid request; → RESP directly on an error.
  - ACC0 → ACC1 if the access is split; otherwise → RESP.
  - ACC1 → RESP.
  - RESP → IDLE unconditionally.
- Access size: size = 1/2/4 from funct3[1:0]. Illegal funct3 (011, 110, 111, or any store funct3 with bit 2 set) → error.
- Offset and split: off = addr[1:0]. Access is split iff off + size > 4.
- Word addresses: beat0 word = addr[MEM_AW+1:2]; beat1 word = beat0 word + 1.
- Range error: addr + size - 1 >= DEPTH_BYTES, computed in 33 bits. A range error guarantees beat1 never wraps.
- Byte mask: mask8 = ({4'b0, size_mask} << off), where size_mask = 0001/0011/1111. Beat0 uses mask8[3:0]; beat1 uses mask8[7:4].
- Write data: wd64 = {32'b0, wdata} << (8*off). Beat0 drives wd64[31:0]; beat1 drives wd64[63:32].
- Memory interface outside ACC0/ACC1: o_mem_wren=0 and o_mem_bmask=0. o_mem_wren is 1 only in ACC states of a store, exactly one cycle per beat.
- Loads:
  - i_mem_rdata is captured at the end of ACC0 (lo) and at the end of ACC1 (hi).
  - Data = ({hi, lo} >> 8*off), truncated to size, then sign-extended (B, H) or zero-extended (BU, HU).
  - For an unsplit load, hi = 0.
- Latency: aligned or unsplit access asserts o_rsp_valid 2 cycles after accept; a split access asserts it 3 cycles after accept; an error response comes 1 cycle after accept.
- o_rsp_valid is high exactly one cycle (RESP). o_rsp_rdata holds its value until the next response.
- Reset mid-operation: returns to IDLE immediately. o_mem_wren drops asynchronously. No response is issued. A beat already written in a split store is not rolled back.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split into two beats as described above.
- Undefined:
  - Any access with (size=2 && off[0]) or (size=4 && off != 0) is an error; no memory access occurs, response after 1 cycle.
  - ACC1 is never entered and may be omitted.

Test Plan:
- Reset with i_rst_n=0 → o_req_ready=1, o_mem_wren=0, o_rsp_valid=0; release and idle 5 cycles → all outputs stay at reset values.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → beat: o_mem_addr=4, bmask=1111, wren one cycle; load response rdata=0xDEADBEEF, 2 cycles after accept.
- SB 0x13 data 0x80, then LB 0x13 and LBU 0x13 → store bmask=1000, wdata[31:24]=0x80; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- With LSU_MISALIGN_SPLIT_EN: SW 0x22 data 0x11223344 → beat0 addr 8, mask 1100, wdata 0x3344xxxx; beat1 addr 9, mask 0011, wdata 0xxxxx1122. LW 0x22 returns 0x11223344, 3 cycles after accept. Without the macro: same SW → err=1, wren never asserted.
- LH 0x7FF (DEPTH_BYTES=2048) → err=1, rdata=0, no memory beat. funct3=011 → err=1.
- Assert i_rst_n=0 during ACC0 of a store → wren drops the same cycle, no rsp_valid; next request is accepted normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl - single-outstanding RV32 load/store initiator for a
// word-addressed, byte-masked data memory (combinational read, synchronous
// byte-masked write).
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   : misaligned accesses that straddle a word boundary are issued
//               as two memory beats (ACC0 then ACC1)
//   undefined : misaligned halfword/word accesses return an error response
//               and never touch memory
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_valid/o_req_ready request handshake (ready only while idle)
//   i_req_we              1 = store, 0 = load
//   i_req_funct3          RV32 access size/sign encoding
//   i_req_addr            byte address
//   i_req_wdata           store data, LSB-aligned
//   o_rsp_valid           one-cycle response strobe
//   o_rsp_rdata           extended load data (0 for stores and errors)
//   o_rsp_err             error flag qualifying o_rsp_valid
//   o_mem_addr            memory word address
//   o_mem_wdata           lane-shifted store data
//   o_mem_bmask           byte enables
//   o_mem_wren            write enable
//   i_mem_rdata           combinational read data for o_mem_addr
module lsu_mem_ctrl #(
  parameter int MEM_AW      = 11,
  parameter int DEPTH_BYTES = 2048
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state_r;
  logic [2:0]  funct3_r;
  logic        we_r;
  logic [1:0]  off_r;
  logic        split_r;
  logic [3:0]  hi_mask_r;
  logic [31:0] hi_wdata_r;
  logic [31:0] lo_r;

  logic [2:0]  size_s;
  logic [3:0]  size_mask_s;
  logic [1:0]  off_s;
  logic        bad_s;
  logic [32:0] last_s;
  logic        range_s;
  logic        misalign_s;
  logic        split_s;
  logic        err_s;
  logic [7:0]  mask8_s;
  logic [63:0] wd64_s;

  // Extract the addressed bytes from the {hi, lo} double word and extend.
  function automatic logic [31:0] extend_load(input logic [63:0] dw,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = 32'(dw >> {off, 3'b000});
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extend_load = sh;
      3'b100:  extend_load = {24'h000000, sh[7:0]};
      3'b101:  extend_load = {16'h0000, sh[15:0]};
      default: extend_load = 32'h00000000;
    endcase
  endfunction

  // Decode the incoming request: size, error classes, split and lane layout.
  always_comb begin
    size_s      = 3'd1;
    size_mask_s = 4'b0001;
    case (i_req_funct3[1:0])
      2'b00:   begin size_s = 3'd1; size_mask_s = 4'b0001; end
      2'b01:   begin size_s = 3'd2; size_mask_s = 4'b0011; end
      2'b10:   begin size_s = 3'd4; size_mask_s = 4'b1111; end
      default: begin size_s = 3'd1; size_mask_s = 4'b0001; end
    endcase
    off_s      = i_req_addr[1:0];
    bad_s      = (i_req_funct3[1:0] == 2'b11) || (i_req_funct3 == 3'b110) ||
                 (i_req_we && i_req_funct3[2]);
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    last_s     = {1'b0, i_req_addr} + {30'd0, size_s} - 33'd1;
    range_s    = (last_s >= 33'(DEPTH_BYTES));
    misalign_s = ((size_s == 3'd2) && off_s[0]) ||
                 ((size_s == 3'd4) && (off_s != 2'b00));
    split_s    = SPLIT_EN && (({1'b0, off_s} + size_s) > 3'd4);
    err_s      = bad_s || range_s || (misalign_s && !SPLIT_EN);
    mask8_s    = {4'b0000, size_mask_s} << off_s;
    wd64_s     = {32'h00000000, i_req_wdata} << {off_s, 3'b000};
  end

  // Request FSM; every memory and response output is driven from a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      funct3_r    <= 3'd0;
      we_r        <= 1'b0;
      off_r       <= 2'd0;
      split_r     <= 1'b0;
      hi_mask_r   <= 4'd0;
      hi_wdata_r  <= 32'd0;
      lo_r        <= 32'd0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_mem_addr  <= {MEM_AW{1'b0}};
      o_mem_wdata <= 32'd0;
      o_mem_bmask <= 4'd0;
      o_mem_wren  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            funct3_r    <= i_req_funct3;
            we_r        <= i_req_we;
            off_r       <= off_s;
            split_r     <= split_s;
            if (err_s) begin
              // errors skip memory entirely and answer next cycle
              state_r     <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= 32'd0;
            end else begin
              state_r     <= ACC0;
              o_mem_addr  <= i_req_addr[MEM_AW+1:2];
              o_mem_bmask <= mask8_s[3:0];
              o_mem_wdata <= wd64_s[31:0];
              o_mem_wren  <= i_req_we;
              // upper halves are held for a possible second beat
              hi_mask_r   <= mask8_s[7:4];
              hi_wdata_r  <= wd64_s[63:32];
            end
          end
        end
        ACC0: begin
          lo_r <= i_mem_rdata;
          if (split_r) begin
            state_r     <= ACC1;
            o_mem_addr  <= o_mem_addr + {{(MEM_AW-1){1'b0}}, 1'b1};
            o_mem_bmask <= hi_mask_r;
            o_mem_wdata <= hi_wdata_r;
            o_mem_wren  <= we_r;
          end else begin
            state_r     <= RESP;
            o_mem_bmask <= 4'd0;
            o_mem_wren  <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= we_r ? 32'd0
                                : extend_load({32'd0, i_mem_rdata}, off_r, funct3_r);
          end
        end
        ACC1: begin
          state_r     <= RESP;
          o_mem_bmask <= 4'd0;
          o_mem_wren  <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= we_r ? 32'd0
                              : extend_load({i_mem_rdata, lo_r}, off_r, funct3_r);
        end
        RESP: begin
          state_r     <= IDLE;
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_req_ready <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_mem_bmask <= 4'd0;
          o_mem_wren  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized
// requests checked against a byte-level reference memory model.
module tb_lsu_mem_ctrl;

  localparam int DEPTH = 2048;
  localparam int AW    = 11;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [2:0]    i_req_funct3;
  logic [31:0]   i_req_addr;
  logic [31:0]   i_req_wdata;
  logic          o_rsp_valid;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_bmask;
  logic          o_mem_wren;
  logic [31:0]   i_mem_rdata;

  logic [7:0] tb_mem  [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];
  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_rdata;

  lsu_mem_ctrl #(.MEM_AW(AW), .DEPTH_BYTES(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Backing memory seen by the DUT: combinational read, byte-masked write.
  always_comb begin
    i_mem_rdata = 32'h0;
    if (int'(o_mem_addr) < DEPTH / 4)
      i_mem_rdata = {tb_mem[int'(o_mem_addr) * 4 + 3], tb_mem[int'(o_mem_addr) * 4 + 2],
                     tb_mem[int'(o_mem_addr) * 4 + 1], tb_mem[int'(o_mem_addr) * 4]};
  end

  always @(posedge i_clk) begin
    if (o_mem_wren && int'(o_mem_addr) < DEPTH / 4)
      for (int k = 0; k < 4; k++)
        if (o_mem_bmask[k]) tb_mem[int'(o_mem_addr) * 4 + k] <= o_mem_wdata[8*k +: 8];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // One request through the DUT, with every expectation taken from the model.
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int size, exp_beats, exp_lat, bi, lat;
    bit bad, range_err, misal, split, err, seen;
    longint a, last, word;
    logic [31:0] exp_rd, exp_wd, lane_m, got_rd;
    logic [3:0]  exp_mask;
    logic        got_err;

    size  = f3_size(f3);
    bad   = (size == 0) || (f3 == 3'b110) || (we && f3[2]);
    a     = longint'(addr);
    last  = a + longint'(size) - 1;
    range_err = !bad && (last >= DEPTH);
    misal = !bad && ((a % size) != 0);
    err   = bad || range_err || (misal && !SPLIT_EN);
    split = !err && ((a >> 2) != (last >> 2));
    exp_beats = err ? 0 : (split ? 2 : 1);
    exp_lat   = err ? 1 : (split ? 3 : 2);

    exp_rd = 32'h0;
    if (!we && !err) begin
      for (int j = 0; j < size; j++) exp_rd[8*j +: 8] = ref_mem[a + j];
      if (!f3[2] && size < 4 && exp_rd[8*size-1]) exp_rd = exp_rd | (32'hFFFFFFFF << (8*size));
    end

    @(negedge i_clk);
    check_eq("req_ready", o_req_ready, 1'b1);
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wdata;
    @(posedge i_clk);
    seen = 0; lat = 0; bi = 0; got_rd = 32'h0; got_err = 1'b0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge i_clk);
      if (c == 1) i_req_valid = 1'b0;
      if (o_mem_bmask != 4'd0) begin
        word = (a >> 2) + bi;
        exp_mask = 4'd0; exp_wd = 32'h0; lane_m = 32'h0;
        for (int j = 0; j < size; j++)
          if (((a + j) >> 2) == word) begin
            exp_mask[(a + j) % 4] = 1'b1;
            exp_wd[8*((a + j) % 4) +: 8] = wdata[8*j +: 8];
            lane_m[8*((a + j) % 4) +: 8] = 8'hFF;
          end
        check_eq("beat_addr", o_mem_addr, word[AW-1:0]);
        check_eq("beat_mask", o_mem_bmask, exp_mask);
        check_eq("beat_wren", o_mem_wren, we);
        if (we) check_eq("beat_wdata", o_mem_wdata & lane_m, exp_wd);
        bi++;
      end else begin
        check_eq("idle_wren", o_mem_wren, 1'b0);
      end
      if (o_rsp_valid) begin
        seen = 1; lat = c; got_rd = o_rsp_rdata; got_err = o_rsp_err;
      end
    end
    if (!seen) begin
      check_eq("rsp_timeout", 1'b0, 1'b1);
    end else begin
      check_eq("rsp_err", got_err, err);
      check_eq("rsp_rdata", got_rd, exp_rd);
      check_eq("rsp_latency", lat, exp_lat);
    end
    check_eq("beat_count", bi, exp_beats);
    @(negedge i_clk);
    check_eq("rsp_pulse", o_rsp_valid, 1'b0);
    last_rdata = got_rd;

    if (we && !err)
      for (int j = 0; j < size; j++) ref_mem[a + j] = wdata[8*j +: 8];
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    logic [2:0]  f3;
    logic [31:0] addr;
    int r;
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
    i_req_funct3 = 3'd0; i_req_addr = 32'd0; i_req_wdata = 32'd0;

    #12;
    check_eq("rst_ready", o_req_ready, 1'b1);
    check_eq("rst_wren", o_mem_wren, 1'b0);
    check_eq("rst_rsp_valid", o_rsp_valid, 1'b0);
    check_eq("rst_rsp_err", o_rsp_err, 1'b0);
    check_eq("rst_rdata", o_rsp_rdata, 32'd0);
    check_eq("rst_mem_addr", o_mem_addr, 11'd0);
    check_eq("rst_mem_wdata", o_mem_wdata, 32'd0);
    check_eq("rst_bmask", o_mem_bmask, 4'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check_eq("idle_outputs", {o_req_ready, o_rsp_valid, o_rsp_err, o_mem_wren, o_mem_bmask,
                                o_rsp_rdata, o_mem_wdata}, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0});
    end

    // directed cases
    do_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0);
    check_eq("lw_0x10", last_rdata, 32'hDEADBEEF);
    do_txn(1'b1, 3'b000, 32'h13, 32'h00000080);
    do_txn(1'b0, 3'b000, 32'h13, 32'h0);
    check_eq("lb_0x13", last_rdata, 32'hFFFFFF80);
    do_txn(1'b0, 3'b100, 32'h13, 32'h0);
    check_eq("lbu_0x13", last_rdata, 32'h00000080);
    do_txn(1'b1, 3'b010, 32'h22, 32'h11223344);
    do_txn(1'b0, 3'b010, 32'h22, 32'h0);
    if (SPLIT_EN) check_eq("lw_0x22", last_rdata, 32'h11223344);
    else          check_eq("lw_0x22", last_rdata, 32'h0);
    do_txn(1'b0, 3'b001, 32'h7FF, 32'h0);
    do_txn(1'b0, 3'b011, 32'h40, 32'h0);
    do_txn(1'b1, 3'b100, 32'h40, 32'h12345678);
    do_txn(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    do_txn(1'b0, 3'b010, 32'h7FC, 32'h0);

    // reset while the first beat of a store is on the memory bus
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b010;
    i_req_addr = 32'h40; i_req_wdata = 32'hCAFEF00D;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    check_eq("acc0_wren", o_mem_wren, 1'b1);
    check_eq("acc0_addr", o_mem_addr, 11'd16);
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_wren", o_mem_wren, 1'b0);
    check_eq("midrst_rsp_valid", o_rsp_valid, 1'b0);
    check_eq("midrst_ready", o_req_ready, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_txn(1'b0, 3'b010, 32'h40, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      addr = 32'($urandom_range(0, 127));
      else if (r < 8) addr = 32'($urandom_range(2036, 2052));
      else            addr = $urandom;
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else                         f3 = 3'($urandom_range(0, 7));
      do_txn(1'($urandom_range(0, 1)), f3, addr, $urandom);
    end

    // memory image must match the reference byte for byte
    for (int i = 0; i < 256; i++) check_eq("mem_image", tb_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
